// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with a multi-cycle burst-rotate sequencer.
// Optional feature: define SHREG_PARITY_EN to register even parity of q.
module universal_shift_reg #(
    parameter int unsigned             WIDTH     = 8,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0,
    parameter int unsigned             CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShr   = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeLoad  = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeAsr   = 3'b110;
    localparam logic [2:0] ModeBurst = 3'b111;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   ror_q;

    assign ror_q = {q_q[0], q_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    unique case (cntrl)
                        ModeHold:  q_d = q_q;
                        ModeShr:   q_d = {sin, q_q[WIDTH-1:1]};
                        ModeShl:   q_d = {q_q[WIDTH-2:0], sin};
                        ModeLoad:  q_d = d;
                        ModeRor:   q_d = ror_q;
                        ModeRol:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        ModeAsr:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                        ModeBurst: begin
                            cnt_d = amt;
                            if (amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = StBusy;
                            end
                        end
                        default:   q_d = q_q;
                    endcase
                end
                StBusy: begin
                    q_d   = ror_q;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = (state_q == StBusy);
    // done_q survives an en=0 stretch; the pulse is only visible in an enabled cycle.
    assign done   = done_q & en;

`ifdef SHREG_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (en) begin
            parity_d = ^q_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= ^RESET_VAL;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule
